pc_update_ras: RTL

//  Parametrised successor to the sequential-core PC update stage. Holds the architectural
//  PC in a register and computes next PC from icode/cond/valP/valC/valM each clock.

---
 rtl/y86_pkg.sv | 28 ++
 rtl/ras_stack.sv | 82 ++++++++
 rtl/pc_update_ras.sv | 121 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, icode width and status encodings.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd1;
    localparam logic [1:0] STAT_HLT = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Codes above I_POPQ are not defined by the ISA.
    function automatic logic icode_invalid(input logic [ICODE_W-1:0] icode);
        return icode > I_POPQ;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack. A push while full overwrites the oldest entry; a pop while
// empty leaves the pointer alone. Overflow/underflow flags are sticky until reset.
module ras_stack #(
    parameter int unsigned AddrW = 64,
    parameter int unsigned Depth = 8
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [AddrW-1:0]           push_data_i,
    output logic [AddrW-1:0]           top_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       full_o,
    output logic                       ovf_o,
    output logic                       unf_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [AddrW-1:0] mem_q [Depth];
    logic [PtrW-1:0]  ptr_q, ptr_d;   // next free slot; top lives at ptr_q - 1
    logic [CntW-1:0]  count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic [PtrW-1:0]  top_idx;
    logic             empty;

    assign top_idx = ptr_q - PtrW'(1);
    assign empty   = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign top_o   = empty ? '0 : mem_q[top_idx];
    assign count_o = count_q;
    assign ovf_o   = ovf_q;
    assign unf_o   = unf_q;

    // Next pointer, count and sticky flags for a push or pop.
    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push_i) begin
            ptr_d = ptr_q + PtrW'(1);
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop_i) begin
            if (empty) begin
                unf_d = 1'b1;
            end else begin
                ptr_d   = top_idx;
                count_d = count_q - CntW'(1);
            end
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Entry storage; contents are don't-care while count is zero so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (!reset_i && push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/pc_update_ras.sv
// PC update stage with return-address stack, stall hold and halt/invalid-instruction latch.
// Define PC_TRACE_EN to compile a simulation-only trace of every enabled update.
module pc_update_ras
    import y86_pkg::*;
#(
    parameter int unsigned          ADDR_W    = 64,
    parameter int unsigned          RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic [ICODE_W-1:0]            icode,
    input  logic                          cond,
    input  logic [ADDR_W-1:0]             valP,
    input  logic [ADDR_W-1:0]             valC,
    input  logic [ADDR_W-1:0]             valM,
    output logic [ADDR_W-1:0]             pc,
    output logic                          halted,
    output logic                          stat_ins,
    output logic [ADDR_W-1:0]             ras_top,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_mismatch,
    output logic                          ras_ovf,
    output logic                          ras_unf
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              halted_q, halted_d;
    logic              stat_ins_q, stat_ins_d;
    logic              mismatch_q, mismatch_d;
    logic              en, push, pop, ras_full;

    assign en = !stall && !halted_q;

    // Next-PC mux, halt latch and RAS push/pop decode.
    always_comb begin
        pc_d       = pc_q;
        halted_d   = halted_q;
        stat_ins_d = stat_ins_q;
        mismatch_d = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        if (en) begin
            case (icode)
                I_HALT: halted_d = 1'b1;
                I_JXX:  pc_d = cond ? valC : valP;
                I_CALL: begin
                    pc_d = valC;
                    push = 1'b1;
                end
                I_RET: begin
                    // Memory is authoritative; the RAS only flags disagreement.
                    pc_d       = valM;
                    pop        = 1'b1;
                    mismatch_d = (ras_count != '0) && (ras_top != valM);
                end
                I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
                    pc_d = valP;
                default: begin
                    halted_d   = 1'b1;
                    stat_ins_d = 1'b1;
                end
            endcase
        end
    end

    // Architectural PC and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            halted_q   <= 1'b0;
            stat_ins_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            halted_q   <= halted_d;
            stat_ins_q <= stat_ins_d;
            mismatch_q <= mismatch_d;
        end
    end

    ras_stack #(
        .AddrW (ADDR_W),
        .Depth (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (valP),
        .top_o       (ras_top),
        .count_o     (ras_count),
        .full_o      (ras_full),
        .ovf_o       (ras_ovf),
        .unf_o       (ras_unf)
    );

    assign pc           = pc_q;
    assign halted       = halted_q;
    assign stat_ins     = stat_ins_q;
    assign ras_mismatch = mismatch_q;

`ifdef PC_TRACE_EN
    // Simulation-only trace of enabled updates and RAS events.
    always @(posedge clk) begin
        if (!reset && en) begin
            $display("%0t pc_update: icode=%h pc %h -> %h ras_count=%0d",
                     $time, icode, pc_q, pc_d, ras_count);
            if (mismatch_d) $display("%0t pc_update: ras mismatch top=%h valM=%h",
                                     $time, ras_top, valM);
            if (push && ras_full) $display("%0t pc_update: ras overflow", $time);
            if (pop && ras_count == '0) $display("%0t pc_update: ras underflow", $time);
        end
    end
`else
    logic unused_full;
    assign unused_full = ras_full;
`endif

endmodule
